// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (core, debug) and the memory.
// The slave modport is the arbiter's view; the master modport is the requesters'/memory's view.
interface dmem_arbiter_if;
    logic        c_req;
    logic        c_we;
    logic [2:0]  c_funct3;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    modport slave (
        input  c_req, c_we, c_funct3, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_funct3, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core has priority, debug is protected by a starvation counter.
// Byte/half stores become read-modify-write sequences against a word-wide memory.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RSP
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        m_en_q, m_en_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        c_rvalid_q, c_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] c_rdata_q, c_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        c_win;
    logic        d_win;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    // Grants are only offered from IDLE; debug overtakes the core once it has waited long enough.
    always_comb begin
        c_win = 1'b0;
        d_win = 1'b0;
        if (!reset && state_q == IDLE) begin
            d_win = bus.d_req && (!bus.c_req || starve_q == LIMIT);
            c_win = bus.c_req && !d_win;
        end
    end

    // funct3[1] set means a full word; otherwise bit 0 picks half vs byte and bit 2 means unsigned.
    always_comb begin
        lane_byte = bus.m_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_half = bus.m_rdata[{addr_q[1], 4'b0000} +: 16];
        load_val  = bus.m_rdata;
        merge_val = bus.m_rdata;
        if (funct3_q[1]) begin
            merge_val = wdata_q;
        end else if (funct3_q[0]) begin
            load_val = funct3_q[2] ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
            merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            load_val = funct3_q[2] ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        owner_d    = owner_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        m_en_d     = 1'b0;
        m_we_d     = 1'b0;
        m_addr_d   = 32'b0;
        m_wdata_d  = 32'b0;
        c_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        c_rdata_d  = 32'b0;
        d_rdata_d  = 32'b0;

        case (state_q)
            IDLE: begin
                if (c_win) begin
                    owner_d  = 1'b0;
                    we_d     = bus.c_we;
                    funct3_d = bus.c_funct3;
                    addr_d   = bus.c_addr;
                    wdata_d  = bus.c_wdata;
                end else if (d_win) begin
                    owner_d  = 1'b1;
                    we_d     = bus.d_we;
                    funct3_d = 3'b010;
                    addr_d   = bus.d_addr;
                    wdata_d  = bus.d_wdata;
                end

                if (d_win || !bus.d_req) begin
                    starve_d = '0;
                end else if (c_win && starve_q != LIMIT) begin
                    starve_d = starve_q + CW'(1);
                end

                // Full-word stores skip the read; everything else starts with a read of the word.
                if (c_win || d_win) begin
                    m_en_d   = 1'b1;
                    m_addr_d = {addr_d[31:2], 2'b00};
                    if (we_d && funct3_d[1]) begin
                        m_we_d    = 1'b1;
                        m_wdata_d = wdata_d;
                        state_d   = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end

            RD: begin
                state_d = CAP;
            end

            CAP: begin
                if (we_q) begin
                    m_en_d    = 1'b1;
                    m_we_d    = 1'b1;
                    m_addr_d  = {addr_q[31:2], 2'b00};
                    m_wdata_d = merge_val;
                    state_d   = WR;
                end else begin
                    if (owner_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = load_val;
                    end else begin
                        c_rvalid_d = 1'b1;
                        c_rdata_d  = load_val;
                    end
                    state_d = RSP;
                end
            end

            WR: begin
                d_rvalid_d = owner_q;
                c_rvalid_d = !owner_q;
                state_d    = RSP;
            end

            RSP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset aborts any access in flight: no later strobe or completion pulse can come out of it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            funct3_q   <= 3'b0;
            addr_q     <= 32'b0;
            wdata_q    <= 32'b0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= 32'b0;
            m_wdata_q  <= 32'b0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= 32'b0;
            d_rdata_q  <= 32'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus.c_gnt    = c_win;
    assign bus.d_gnt    = d_win;
    assign bus.c_rvalid = c_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.c_rdata  = c_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.m_en     = m_en_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with reset pulses.
module tb_dmem_arbiter;

    localparam int LIMIT = 2;

    logic clk = 1'b0;
    logic reset;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    // Reference model state: one transaction in flight, timed from its grant cycle.
    bit          hold_reqs;
    bit          busy;
    bit          mdl_c_granted;
    bit          mdl_d_granted;
    int          starve;
    int          g_cyc;
    int          lat;
    bit          mdl_dbg;
    bit          mdl_we;
    logic [31:0] mdl_addr;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wword;

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] t;
        t = 32'(i);
        if (i == 24) return 32'hAA0B_C0DD;
        return 32'h1357_9BDF ^ (t * 32'h0101_0101);
    endfunction

    // Word-wide memory: reads land on m_rdata during the RD cycle and stay through CAP.
    initial begin
        bus.m_rdata = 32'b0;
        for (int i = 0; i < 64; i++) mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (bus.m_en) begin
                if (bus.m_we) mem[bus.m_addr[7:2]] = bus.m_wdata;
                else          bus.m_rdata = mem[bus.m_addr[7:2]];
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h cycle=%0d", name, act, expv, cyc);
        end
    endtask

    function automatic int access_bytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    task automatic start_txn(input bit dbg, input bit we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] word, v, mask;
        int nb, sh;
        bit uns;
        mdl_dbg  = dbg;
        mdl_we   = we;
        mdl_addr = addr;
        nb  = access_bytes(f3);
        uns = (f3 == 3'b100) || (f3 == 3'b101);
        word = ref_mem[addr[7:2]];
        if (nb == 4) begin
            v = word;
            exp_wword = wd;
        end else begin
            sh   = (nb == 1) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
            mask = ((nb == 1) ? 32'hFF : 32'hFFFF) << sh;
            v = (word & mask) >> sh;
            if (!uns && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!uns && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
            exp_wword = (word & ~mask) | ((wd << sh) & mask);
        end
        exp_rdata = v;
        lat = !we ? 3 : ((nb == 4) ? 2 : 4);
    endtask

    task automatic model_cycle();
        logic e_cg, e_dg, e_en, e_we, e_cv, e_dv;
        logic [31:0] e_addr, e_wd, e_cr, e_dr;
        bit done, wr_now, rd_now;
        int k;
        e_cg = 0; e_dg = 0; e_en = 0; e_we = 0; e_cv = 0; e_dv = 0;
        e_addr = 0; e_wd = 0; e_cr = 0; e_dr = 0;
        done = 0;
        mdl_c_granted = 0;
        mdl_d_granted = 0;
        if (reset) begin
            busy   = 0;
            starve = 0;
        end else if (busy) begin
            k      = cyc - g_cyc;
            wr_now = mdl_we && ((lat == 2 && k == 1) || (lat == 4 && k == 3));
            rd_now = (k == 1) && (lat != 2);
            e_en   = wr_now || rd_now;
            e_we   = wr_now;
            e_addr = {mdl_addr[31:2], 2'b00};
            e_wd   = exp_wword;
            if (k == lat) begin
                done = 1;
                if (mdl_dbg) begin e_dv = 1; e_dr = mdl_we ? 32'b0 : exp_rdata; end
                else         begin e_cv = 1; e_cr = mdl_we ? 32'b0 : exp_rdata; end
            end
            if (wr_now) ref_mem[mdl_addr[7:2]] = exp_wword;
        end else begin
            if (bus.d_req && (!bus.c_req || starve == LIMIT)) mdl_d_granted = 1;
            else if (bus.c_req)                               mdl_c_granted = 1;
            if (mdl_d_granted || !bus.d_req)        starve = 0;
            else if (mdl_c_granted && starve < LIMIT) starve++;
            e_cg = mdl_c_granted;
            e_dg = mdl_d_granted;
            if (mdl_c_granted) start_txn(0, bus.c_we, bus.c_funct3, bus.c_addr, bus.c_wdata);
            if (mdl_d_granted) start_txn(1, bus.d_we, 3'b010, bus.d_addr, bus.d_wdata);
            if (mdl_c_granted || mdl_d_granted) begin
                busy  = 1;
                g_cyc = cyc;
            end
        end
        check_output("c_gnt", 32'(bus.c_gnt), 32'(e_cg));
        check_output("d_gnt", 32'(bus.d_gnt), 32'(e_dg));
        check_output("m_en", 32'(bus.m_en), 32'(e_en));
        if (e_en) begin
            check_output("m_we", 32'(bus.m_we), 32'(e_we));
            check_output("m_addr", bus.m_addr, e_addr);
            if (e_we) check_output("m_wdata", bus.m_wdata, e_wd);
        end
        check_output("c_rvalid", 32'(bus.c_rvalid), 32'(e_cv));
        check_output("d_rvalid", 32'(bus.d_rvalid), 32'(e_dv));
        check_output("c_rdata", bus.c_rdata, e_cr);
        check_output("d_rdata", bus.d_rdata, e_dr);
        if (done) busy = 0;
        cyc++;
    endtask

    // A requester drops its request once the model says it was granted.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold_reqs) begin
            if (mdl_c_granted) bus.c_req = 1'b0;
            if (mdl_d_granted) bus.d_req = 1'b0;
        end
    endtask

    task automatic eval();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic apply_stimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic [31:0] rdata, output int rlat,
                                  output int rd_off, output int wr_off,
                                  output logic [31:0] wr_addr, output logic [31:0] wr_data);
        int g;
        g = -1; rlat = -1; rd_off = -1; wr_off = -1;
        rdata = 32'hDEAD_BEEF; wr_addr = 32'b0; wr_data = 32'b0;
        tick();
        bus.c_req = 1'b1; bus.c_we = we; bus.c_funct3 = f3; bus.c_addr = addr; bus.c_wdata = wd;
        eval();
        for (int i = 0; i < 12 && rlat < 0; i++) begin
            if (i > 0) begin tick(); eval(); end
            if (g < 0) begin
                if (bus.c_gnt) g = i;
            end else begin
                if (bus.m_en && !bus.m_we && rd_off < 0) rd_off = i - g;
                if (bus.m_en && bus.m_we) begin
                    wr_off = i - g; wr_addr = bus.m_addr; wr_data = bus.m_wdata;
                end
                if (bus.c_rvalid) begin rlat = i - g; rdata = bus.c_rdata; end
            end
        end
    endtask

    logic [31:0] rd, wa, wdv;
    int rl, ro, wo, n, seq, g1, g2, bad;
    bit found;

    initial begin
        hold_reqs = 0; busy = 0; starve = 0; g_cyc = 0; lat = 0;
        mdl_c_granted = 0; mdl_d_granted = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        reset = 1'b1;
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_funct3 = 3'b0; bus.c_addr = 32'b0; bus.c_wdata = 32'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'b0; bus.d_wdata = 32'b0;

        @(posedge clk); #1;
        eval();
        check_output("reset_c_gnt", 32'(bus.c_gnt), 0);
        check_output("reset_d_gnt", 32'(bus.d_gnt), 0);
        check_output("reset_m_en", 32'(bus.m_en), 0);
        check_output("reset_c_rvalid", 32'(bus.c_rvalid), 0);
        tick();
        reset = 1'b0; bus.c_req = 1'b0; bus.d_req = 1'b0;
        eval();

        apply_stimulus(0, 3'b000, 32'd97, 32'd0, rd, rl, ro, wo, wa, wdv);
        check_output("lb_rd_off", ro, 1);
        check_output("lb_lat", rl, 3);
        check_output("lb_rdata", rd, 32'hFFFF_FFC0);

        apply_stimulus(0, 3'b101, 32'd98, 32'd0, rd, rl, ro, wo, wa, wdv);
        check_output("lhu_rdata", rd, 32'h0000_AA0B);
        apply_stimulus(0, 3'b001, 32'd96, 32'd0, rd, rl, ro, wo, wa, wdv);
        check_output("lh_rdata", rd, 32'hFFFF_C0DD);

        apply_stimulus(1, 3'b000, 32'd99, 32'h33, rd, rl, ro, wo, wa, wdv);
        check_output("sb_wr_off", wo, 3);
        check_output("sb_wr_addr", wa, 32'd96);
        check_output("sb_wr_data", wdv, 32'h330B_C0DD);
        check_output("sb_lat", rl, 4);

        apply_stimulus(1, 3'b010, 32'd100, 32'd25, rd, rl, ro, wo, wa, wdv);
        check_output("sw_wr_off", wo, 1);
        check_output("sw_wr_addr", wa, 32'd100);
        check_output("sw_wr_data", wdv, 32'd25);
        check_output("sw_lat", rl, 2);
        check_output("sw_no_rd", ro, -1);

        // Both requesters held high: expected order core,core,debug,core,core,debug.
        tick();
        hold_reqs = 1;
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_funct3 = 3'b010; bus.c_addr = 32'd0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd6;
        eval();
        n = 0; seq = 0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            if (i > 0) begin tick(); eval(); end
            if (bus.c_gnt) begin seq = seq * 2;     n++; end
            if (bus.d_gnt) begin seq = seq * 2 + 1; n++; end
        end
        check_output("starve_grants", n, 6);
        check_output("starve_order", seq, 9);
        tick();
        hold_reqs = 0; bus.c_req = 1'b0; bus.d_req = 1'b0;
        eval();
        repeat (5) begin tick(); eval(); end

        // Back-to-back word stores: one grant every 3 cycles.
        tick();
        hold_reqs = 1;
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_funct3 = 3'b010; bus.c_addr = 32'd104; bus.c_wdata = 32'd7;
        eval();
        g1 = -1; g2 = -1;
        for (int i = 0; i < 20 && g2 < 0; i++) begin
            if (i > 0) begin tick(); eval(); end
            if (bus.c_gnt) begin
                if (g1 < 0) g1 = i;
                else        g2 = i;
            end
        end
        check_output("sw_throughput", g2 - g1, 3);
        tick();
        hold_reqs = 0; bus.c_req = 1'b0;
        eval();
        repeat (4) begin tick(); eval(); end

        // Reset lands in CAP of a byte store; the store must vanish and a grant follow at once.
        tick();
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_funct3 = 3'b000; bus.c_addr = 32'd97; bus.c_wdata = 32'h5A;
        eval();
        check_output("abort_gnt", 32'(bus.c_gnt), 1);
        tick(); eval();
        check_output("abort_rd", 32'(bus.m_en), 1);
        tick();
        reset = 1'b1;
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_funct3 = 3'b010; bus.c_addr = 32'd96;
        eval();
        check_output("abort_m_en", 32'(bus.m_en), 0);
        check_output("abort_rvalid", 32'(bus.c_rvalid), 0);
        check_output("abort_gnt_in_reset", 32'(bus.c_gnt), 0);
        tick();
        reset = 1'b0;
        eval();
        check_output("post_reset_gnt", 32'(bus.c_gnt), 1);
        check_output("post_reset_no_wr", 32'(bus.m_en), 0);
        found = 0; rd = 32'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            tick(); eval();
            if (bus.c_rvalid) begin found = 1; rd = bus.c_rdata; end
        end
        check_output("post_reset_load", rd, 32'h330B_C0DD);
        check_output("abort_mem_kept", mem[24], 32'h330B_C0DD);

        // Randomized traffic with occasional one-cycle reset pulses.
        for (int t = 0; t < 2500; t++) begin
            tick();
            reset = ($urandom_range(0, 199) == 0);
            if (!bus.c_req && $urandom_range(0, 1) == 1) begin
                bus.c_req    = 1'b1;
                bus.c_we     = 1'($urandom_range(0, 1));
                bus.c_funct3 = 3'($urandom_range(0, 7));
                bus.c_addr   = 32'($urandom_range(0, 255));
                bus.c_wdata  = $urandom;
            end
            if (!bus.d_req && $urandom_range(0, 3) == 0) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = 32'($urandom_range(0, 255));
                bus.d_wdata = $urandom;
            end
            eval();
        end
        tick();
        reset = 1'b0; bus.c_req = 1'b0; bus.d_req = 1'b0;
        eval();
        repeat (6) begin tick(); eval(); end

        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        check_output("mem_final", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive core grants allowed while the debug port is waiting.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port c_req  in  1  core load/store request; held until granted.
REQ-005 SHALL have port c_we  in  1  core request is a store (1) or a load (0).
REQ-006 SHALL have port c_funct3  in  3  access size: 000 b, 001 h, 010 w, 100 bu, 101 hu; other codes are treated as w.
REQ-007 SHALL have port c_addr  in  32  core byte address.
REQ-008 SHALL have port c_wdata  in  32  core store data, right-aligned (bits [7:0] for b, [15:0] for h).
REQ-009 SHALL have port c_gnt  out  1  core request accepted this cycle.
REQ-010 SHALL have port c_rvalid  out  1  one-cycle completion pulse for the core (loads and stores).
REQ-011 SHALL have port c_rdata  out  32  extended load result; valid while c_rvalid=1.
REQ-012 SHALL have port d_req  in  1  debug/loader request; word-only.
REQ-013 SHALL have port d_we  in  1  debug request is a store.
REQ-014 SHALL have port d_addr  in  32  debug byte address; bits [1:0] are ignored.
REQ-015 SHALL have port d_wdata  in  32  debug store word.
REQ-016 SHALL have port d_gnt  out  1  debug request accepted this cycle.
REQ-017 SHALL have port d_rvalid  out  1  one-cycle completion pulse for the debug port.
REQ-018 SHALL have port d_rdata  out  32  debug load word; valid while d_rvalid=1.
REQ-019 SHALL have port m_en  out  1  memory access strobe.
REQ-020 SHALL have port m_we  out  1  memory write (qualified by m_en).
REQ-021 SHALL have port m_addr  out  32  word-aligned address, with [1:0]=00.
REQ-022 SHALL have port m_wdata  out  32  full write word.
REQ-023 SHALL have port m_rdata  in  32  read word, valid the cycle after m_en=1 with m_we=0.

Function
REQ-024 SHALL implement the FSM states IDLE, RD, CAP, WR, RSP; grants SHALL occur only in IDLE, combinationally from the req inputs; at most one of c_gnt/d_gnt SHALL be high.
REQ-025 SHALL latch the winner's we, funct3, addr and wdata on the grant edge; requester inputs SHALL be ignored outside IDLE.
REQ-026 SHALL follow these transitions: load IDLE->RD->CAP->RSP (rvalid at T+3, grant at T); word store IDLE->WR->RSP (rvalid at T+2); b/h store IDLE->RD->CAP->WR->RSP (rvalid at T+4); RSP->IDLE always.
REQ-027 SHALL drive m_en=1, m_we=0 in RD; m_en=1, m_we=1 in WR; m_en=0 in every other state.
REQ-028 SHALL register m_rdata in CAP: loads extract the byte lane addr[1:0] or the half lane addr[1], then sign-extend (b, h) or zero-extend (bu, hu).
REQ-029 SHALL, for b/h stores in CAP, merge wdata into the addressed lane of m_rdata, leaving the other lanes unchanged; the result is the WR m_wdata.
REQ-030 SHALL treat a half access with addr[0]=1 as the lane selected by addr[1] (no misalignment fault).
REQ-031 SHALL pulse rvalid only in RSP, only to the granted requester; rdata SHALL be 0 when rvalid=0.
REQ-032 SHALL arbitrate simultaneous requests with core priority, except that debug SHALL win when starve_cnt == STARVE_LIMIT.
REQ-033 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on a core grant made while d_req=1, and clear it on a debug grant or whenever d_req=0 in IDLE.
REQ-034 SHALL let a new grant in IDLE follow RSP directly, giving a back-to-back word-store throughput of one per 3 cycles.

Reset
REQ-035 SHALL, while reset=1 (including mid-access), force state=IDLE, starve_cnt=0, all outputs 0, and latched request fields 0, with no rvalid or m_en issued for an aborted access.
REQ-036 SHALL allow a grant in the first cycle after reset deasserts.

Verification
REQ-037 SHALL verify: mem[96]=0xAA0BC0DD; core lb addr 97 -> m_en/RD at T+1, c_rvalid at T+3, c_rdata=0xFFFFFFC0.
REQ-038 SHALL verify: mem[96]=0xAA0BC0DD; core lhu addr 98 -> c_rdata=0x0000AA0B; lh addr 96 -> 0xFFFFC0DD.
REQ-039 SHALL verify: core sb addr 99 wdata 0x33 -> WR at T+3 with m_addr=96, m_wdata=0x330BC0DD; c_rvalid at T+4.
REQ-040 SHALL verify: core sw addr 100 wdata 25 -> m_en=m_we=1, m_addr=100, m_wdata=25 at T+1; c_rvalid at T+2; no RD cycle.
REQ-041 SHALL verify: STARVE_LIMIT=2 with c_req and d_req held high -> grant order core, core, debug, core, core, debug.
REQ-042 SHALL verify: reset asserted in CAP of a b store -> no WR and no rvalid; memory unchanged; a grant is possible the cycle after release.
